latch_bank_arbiter: RTL
=======================

// Module: latch_bank_arbiter
// PURPOSE
//  Shares one bank of 2**ADDR_W level-sensitive D latches (DATA_W bits each) among N_REQ requesters.
//  Round-robin arbitration; per write: SETUP -> OPEN -> HOLD gate sequence so D is stable around the gate.
//  Sits between requesters and the latch bank; sole driver of the latch gates (Clk pins) and data.
// PARAMETERS
//  N_REQ    4  number of requesters (>=2)
//  DATA_W   8  latch word width
//  ADDR_W   2  latch select width; bank has 2**ADDR_W latches
//  OPEN_CYC 1  cycles latch_en held high per write (>=1)
// PORTS
//  Clk        in   1              system clock, rising edge
//  Reset_n    in   1              async reset, active-low
//  req        in   N_REQ          per-requester write request; hold until gnt
//  req_addr   in   N_REQ*ADDR_W   packed target latch index, slice i = requester i
//  req_data   in   N_REQ*DATA_W   packed write data, slice i = requester i
//  gnt        out  N_REQ          one-hot, 1-cycle completion ack
//  busy       out  1              1 whenever state != IDLE
//  latch_d    out  DATA_W         data to all latch D pins
//  latch_en   out  2**ADDR_W      one-hot gate to latch Clk pins
// BEHAVIOUR
//  - Reset_n=0 (async, any state): state=IDLE, rr_ptr=0, all outputs 0; aborted write gets no gnt.
//  - All outputs registered: latch_en must be glitch-free. Outputs come from flops only, never decoded
//    combinationally from state.
//  - IDLE: if req!=0, pick first set bit searching rr_ptr, rr_ptr+1, ... wrapping mod N_REQ.
//    Capture idx, addr and data; go to SETUP.
//  - SETUP (1 cyc): latch_d=captured data, latch_en=0.
//  - OPEN (OPEN_CYC cyc): latch_en[addr]=1, latch_d unchanged.
//  - HOLD (1 cyc): latch_en=0, latch_d unchanged, gnt[idx]=1. Next state IDLE; rr_ptr=(idx+1) mod N_REQ.
//  - Latency: req sampled in IDLE -> gnt exactly 2+OPEN_CYC cycles later.
//    IDLE lasts >=1 cycle between writes, so a requester deasserting req on gnt is never re-granted.
//  - req or req_data changing after capture is ignored until the next IDLE.
//  - latch_d holds its last value in IDLE; no reset of latch contents except via the optional clear.
//  - busy=1 in SETUP, OPEN, HOLD (and CLEAR).
//  - A second-cycle counter for OPEN is $clog2(OPEN_CYC+1) bits, reloaded on entry to OPEN.
// CONFIGURATION
//  LATCH_BANK_CLEAR_EN defined:
//  - Adds ports clr_req (in, 1), latch_rst (out, 1) and clr_done (out, 1).
//  - In IDLE, clr_req beats any req and enters CLEAR (1 cyc): latch_rst=1, latch_en=0.
//  - Next cycle clr_done=1 for 1 cycle and state returns to IDLE; rr_ptr unchanged.
//  - latch_rst and clr_done reset to 0.
//  LATCH_BANK_CLEAR_EN undefined: these ports and the CLEAR state do not exist.
// STRUCTURE
//  - Shared include lba_defs.vh holds the state encodings:
//    IDLE=3'd0, SETUP=3'd1, OPEN=3'd2, HOLD=3'd3, CLEAR=3'd4.
//  - Sub-module rr_arbiter: inputs req and rr_ptr; outputs one-hot grant and binary idx.
//    rr_arbiter is purely combinational and parameterised by N_REQ.
//  - Top module: FSM, capture registers, OPEN counter and registered outputs.
// TESTING (N_REQ=4, DATA_W=8, ADDR_W=2, OPEN_CYC=1 unless noted)
//  1. Reset_n=0 mid-sim -> same delta: latch_en=0, gnt=0, busy=0, latch_d=0.
//  2. req=0001, addr0=2, data0=8'hA5 -> SETUP: latch_d=A5.
//     Next cycle latch_en=0100; next cycle latch_en=0000 and gnt=0001; then busy=0.
//  3. req=1111 held, each requester drops on its gnt and re-raises -> gnt order 0001, 0010, 0100, 1000, 0001.
//  4. Reset_n=0 during OPEN -> latch_en=0 immediately, no gnt.
//     After release with req=1000 -> serviced, gnt=1000 (rr_ptr was 0).
//  5. OPEN_CYC=3, req=0100, addr2=3 -> latch_en=1000 exactly 3 cycles; gnt 5 cycles after sampling.
//  6. LATCH_BANK_CLEAR_EN, clr_req=1 with req=0001 in IDLE -> latch_rst=1 for 1 cycle, then clr_done=1.
//     Then req0 serviced with gnt=0001.

Source files
------------

// File: rtl/latch_bank_arbiter_pkg.sv
// Shared definitions for the latch bank arbiter.
// Holds the FSM state encoding used by the top level.
// Build macro: LATCH_BANK_CLEAR_EN adds the CLEAR state (bank-wide latch reset).
package latch_bank_arbiter_pkg;

    // Write sequence states; CLEAR exists only when the clear feature is built in.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        OPEN  = 3'd2,
        HOLD  = 3'd3
`ifdef LATCH_BANK_CLEAR_EN
        ,
        CLEAR = 3'd4
`endif
    } state_t;

    // Round-robin successor of a requester index.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n_req);
        return (idx + 1 >= n_req) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/latch_bank_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
// Searches req starting at rr_ptr, wrapping modulo N_REQ, and returns the
// first set bit both as a one-hot grant and as a binary index.
// grant is all-zero when req is all-zero (idx is then 0 and meaningless).
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] idx
);

    logic [N_REQ-1:0] rotated;
    logic [IDX_W-1:0] offset;
    logic [IDX_W:0]   sum;

    // Rotate req so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        rotated = N_REQ'({req, req} >> rr_ptr);
        offset  = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = IDX_W'(i);
            end
        end
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= (IDX_W + 1)'(N_REQ)) begin
            sum = sum - (IDX_W + 1)'(N_REQ);
        end
        idx   = sum[IDX_W-1:0];
        grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            grant[i] = (|req) && (idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter: shares one bank of 2**ADDR_W level-sensitive latches
// among N_REQ requesters. Each write runs SETUP -> OPEN (OPEN_CYC cycles) ->
// HOLD so the latch D input is stable before, during and after the gate.
// Every output is a flop; nothing is decoded combinationally from state, so
// the latch gates cannot glitch.
// Build macro: LATCH_BANK_CLEAR_EN adds clr_req / latch_rst / clr_done and
// the CLEAR state.
module latch_bank_arbiter
    import latch_bank_arbiter_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 2,
    parameter int OPEN_CYC = 1
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_data,
`ifdef LATCH_BANK_CLEAR_EN
    input  logic                     clr_req,
    output logic                     latch_rst,
    output logic                     clr_done,
`endif
    output logic [N_REQ-1:0]         gnt,
    output logic                     busy,
    output logic [DATA_W-1:0]        latch_d,
    output logic [(2**ADDR_W)-1:0]   latch_en
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int N_LATCH = 2 ** ADDR_W;
    localparam int CNT_W   = $clog2(OPEN_CYC + 1);

    state_t              state, state_next;
    logic [IDX_W-1:0]    rr_ptr, rr_ptr_next;
    logic [IDX_W-1:0]    cap_idx, cap_idx_next;
    logic [N_REQ-1:0]    cap_gnt, cap_gnt_next;
    logic [ADDR_W-1:0]   cap_addr, cap_addr_next;
    logic [CNT_W-1:0]    open_cnt, open_cnt_next;

    logic [N_REQ-1:0]    gnt_next;
    logic                busy_next;
    logic [DATA_W-1:0]   latch_d_next;
    logic [N_LATCH-1:0]  latch_en_next;
`ifdef LATCH_BANK_CLEAR_EN
    logic                latch_rst_next;
    logic                clr_done_next;
`endif

    logic [N_REQ-1:0]    win_grant;
    logic [IDX_W-1:0]    win_idx;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic [N_LATCH-1:0]  addr_dec;
    logic [IDX_W-1:0]    ptr_after;

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr_arbiter (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (win_grant),
        .idx    (win_idx)
    );

    // Winner's address/data slices, gate decode of the captured address and
    // the pointer value that follows the captured winner.
    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_addr = win_addr | ({ADDR_W{win_grant[i]}} & req_addr[i*ADDR_W +: ADDR_W]);
            win_data = win_data | ({DATA_W{win_grant[i]}} & req_data[i*DATA_W +: DATA_W]);
        end
        addr_dec = '0;
        for (int i = 0; i < N_LATCH; i++) begin
            addr_dec[i] = (cap_addr == ADDR_W'(i));
        end
        ptr_after = IDX_W'(rr_next(int'(cap_idx), N_REQ));
    end

    // Next-state logic plus the next value of every registered output.
    always_comb begin
        state_next    = state;
        rr_ptr_next   = rr_ptr;
        cap_idx_next  = cap_idx;
        cap_gnt_next  = cap_gnt;
        cap_addr_next = cap_addr;
        open_cnt_next = open_cnt;
        gnt_next      = '0;
        busy_next     = 1'b0;
        latch_d_next  = latch_d;
        latch_en_next = '0;
`ifdef LATCH_BANK_CLEAR_EN
        latch_rst_next = 1'b0;
        clr_done_next  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
`ifdef LATCH_BANK_CLEAR_EN
                if (clr_req) begin
                    state_next     = CLEAR;
                    latch_rst_next = 1'b1;
                    busy_next      = 1'b1;
                end else
`endif
                if (|req) begin
                    state_next    = SETUP;
                    cap_idx_next  = win_idx;
                    cap_gnt_next  = win_grant;
                    cap_addr_next = win_addr;
                    latch_d_next  = win_data;
                    busy_next     = 1'b1;
                end
            end
            SETUP: begin
                state_next    = OPEN;
                open_cnt_next = CNT_W'(OPEN_CYC);
                latch_en_next = addr_dec;
                busy_next     = 1'b1;
            end
            OPEN: begin
                busy_next = 1'b1;
                if (open_cnt == CNT_W'(1)) begin
                    state_next = HOLD;
                    gnt_next   = cap_gnt;
                end else begin
                    open_cnt_next = open_cnt - CNT_W'(1);
                    latch_en_next = addr_dec;
                end
            end
            HOLD: begin
                state_next  = IDLE;
                rr_ptr_next = ptr_after;
            end
`ifdef LATCH_BANK_CLEAR_EN
            CLEAR: begin
                state_next    = IDLE;
                clr_done_next = 1'b1;
            end
`endif
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, capture registers, OPEN counter and output flops.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: capture registers are reset too; an aborted write must leave no stale gnt behind.
            state    <= IDLE;
            rr_ptr   <= '0;
            cap_idx  <= '0;
            cap_gnt  <= '0;
            cap_addr <= '0;
            open_cnt <= '0;
            gnt      <= '0;
            busy     <= 1'b0;
            latch_d  <= '0;
            latch_en <= '0;
`ifdef LATCH_BANK_CLEAR_EN
            latch_rst <= 1'b0;
            clr_done  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= state_next;
            rr_ptr   <= rr_ptr_next;
            cap_idx  <= cap_idx_next;
            cap_gnt  <= cap_gnt_next;
            cap_addr <= cap_addr_next;
            open_cnt <= open_cnt_next;
            gnt      <= gnt_next;
            busy     <= busy_next;
            latch_d  <= latch_d_next;
            latch_en <= latch_en_next;
`ifdef LATCH_BANK_CLEAR_EN
            latch_rst <= latch_rst_next;
            clr_done  <= clr_done_next;
`endif
        end
    end

endmodule
